// File: rtl/tile_reader_pkg.sv
// Shared types and constants for the tile FIFO drain path.
package tile_reader_pkg;

   localparam int TILE_ELEMS = 16;
   localparam int DEF_WIDTH  = 16;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      LOAD,
      STREAM
   } tile_reader_state_t;

   // Tile word at the default element width; parameterised modules size
   // their tiles as TILE_ELEMS*WIDTH instead.
   typedef logic [TILE_ELEMS*DEF_WIDTH-1:0] tile_t;

endpackage

// File: rtl/tile_prefetch_buf.sv
// Single-entry tile holding register with a valid bit.
// Only instantiated by tile_reader when TILE_READER_PREFETCH_EN is defined.
module tile_prefetch_buf
   import tile_reader_pkg::*;
#(
   parameter int WIDTH = 16
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        load,
   input  logic                        take,
   input  logic [TILE_ELEMS*WIDTH-1:0] din,
   output logic [TILE_ELEMS*WIDTH-1:0] dout,
   output logic                        valid
);

   always_ff @(posedge clk) begin
      if (!reset) begin
         dout  <= '0;
         valid <= 1'b0;
      end else if (load) begin
         dout  <= din;
         valid <= 1'b1;
      end else if (take) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/tile_reader.sv
// Pops tiles from the tile FIFO and streams them out element by element.
// Define TILE_READER_PREFETCH_EN to add a one-tile prefetch for zero-bubble tiles.
//
// state  | meaning
// IDLE   | no tile held; waits for a non-empty FIFO (or a landed prefetch)
// REQ    | fifo_read pulse
// LOAD   | FIFO read data captured into the tile register
// STREAM | presenting elements 0..15 on the valid/ready port
module tile_reader
   import tile_reader_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int ELEMS = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   fifo_empty,
   output logic                   fifo_read,
   input  logic [ELEMS*WIDTH-1:0] fifo_out,
   output logic [WIDTH-1:0]       out_data,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic                   out_last,
   output logic                   busy
);

   localparam logic [3:0] LAST_CNT = 4'(ELEMS - 1);

   tile_reader_state_t     state_q, state_d;
   logic [3:0]             cnt_q, cnt_d;
   logic [ELEMS*WIDTH-1:0] tile_q, tile_d;

   logic                   pf_valid;
   logic                   pf_inflight;
   logic                   pf_read;
   logic                   pf_take;
   logic [ELEMS*WIDTH-1:0] pf_data;

`ifdef TILE_READER_PREFETCH_EN
   logic pf_read_q, pf_pend_q;

   // The pop decision is registered so fifo_read never depends on inputs
   // in the same cycle; only we pop, so fifo_empty cannot rise in between.
   always_ff @(posedge clk) begin
      if (!reset) begin
         pf_read_q <= 1'b0;
         pf_pend_q <= 1'b0;
      end else begin
         pf_read_q <= (state_q == STREAM) && !pf_valid && !pf_read_q
                      && !pf_pend_q && !fifo_empty;
         pf_pend_q <= pf_read_q;
      end
   end

   tile_prefetch_buf #(.WIDTH(WIDTH)) u_pf (
      .clk   (clk),
      .reset (reset),
      .load  (pf_pend_q),
      .take  (pf_take),
      .din   (fifo_out),
      .dout  (pf_data),
      .valid (pf_valid)
   );

   assign pf_inflight = pf_read_q | pf_pend_q;
   assign pf_read     = pf_read_q;
`else
   assign pf_valid    = 1'b0;
   assign pf_inflight = 1'b0;
   assign pf_read     = 1'b0;
   assign pf_data     = '0;
   wire   unused_pf_take = pf_take;
`endif

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         tile_q  <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tile_q  <= tile_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      tile_d  = tile_q;
      pf_take = 1'b0;
      case (state_q)
         IDLE: begin
            // A prefetch still in flight when streaming ended must be used
            // before popping again, otherwise tile order would break.
            if (pf_valid) begin
               tile_d  = pf_data;
               cnt_d   = '0;
               pf_take = 1'b1;
               state_d = STREAM;
            end else if (!pf_inflight && !fifo_empty) begin
               state_d = REQ;
            end
         end
         REQ: begin
            state_d = LOAD;
         end
         LOAD: begin
            tile_d  = fifo_out;
            cnt_d   = '0;
            state_d = STREAM;
         end
         STREAM: begin
            if (out_ready) begin
               cnt_d = cnt_q + 4'd1;
               if (cnt_q == LAST_CNT) begin
                  if (pf_valid) begin
                     tile_d  = pf_data;
                     pf_take = 1'b1;
                  end else begin
                     state_d = IDLE;
                  end
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   assign out_valid = (state_q == STREAM);
   assign out_data  = tile_q[cnt_q*WIDTH +: WIDTH];
   assign out_last  = out_valid && (cnt_q == LAST_CNT);
   assign busy      = (state_q != IDLE);
   assign fifo_read = (state_q == REQ) | pf_read;

endmodule

// File: tb/tb_tile_reader.sv
// Self-checking bench for tile_reader: FIFO model plus element scoreboard.
module tb_tile_reader;

   localparam int W  = 16;
   localparam int TW = 16 * W;

   logic          clk = 1'b0;
   logic          reset = 1'b0;
   logic          fifo_empty = 1'b1;
   logic          fifo_read;
   logic [TW-1:0] fifo_out = '0;
   logic [W-1:0]  out_data;
   logic          out_valid;
   logic          out_ready = 1'b0;
   logic          out_last;
   logic          busy;

   always #5 clk = ~clk;

   tile_reader #(.WIDTH(W), .ELEMS(16)) dut (
      .clk        (clk),
      .reset      (reset),
      .fifo_empty (fifo_empty),
      .fifo_read  (fifo_read),
      .fifo_out   (fifo_out),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .busy       (busy)
   );

   typedef struct {
      logic [W-1:0] data;
      logic         last;
      int           idx;
   } beat_t;

   logic [TW-1:0] push_q[$];
   logic [TW-1:0] fifo_q[$];
   beat_t         exp_q[$];

   int total = 0;
   int bad   = 0;
   int pushed = 0, pops = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got=%0h want=%0h", tag, got, want);
      end
   endtask

   // FIFO model; every popped tile the DUT keeps becomes 16 expected beats.
   always @(posedge clk) begin
      logic [TW-1:0] t;
      beat_t b;
      if (fifo_read && fifo_q.size() > 0) begin
         t = fifo_q.pop_front();
         fifo_out <= t;
         pops++;
         if (reset) begin
            for (int k = 0; k < 16; k++) begin
               b.data = t[k*W +: W];
               b.last = (k == 15);
               b.idx  = k;
               exp_q.push_back(b);
            end
         end
      end
      if (!reset) exp_q.delete();
      while (push_q.size() > 0) fifo_q.push_back(push_q.pop_front());
      fifo_empty <= (fifo_q.size() == 0);
   end

   int cyc = 0, rd_cnt = 0, fall_cyc = -1, first_rd = -1, first_valid = -1;
   int run = 0, max_run = 0, last_m = -1, min_gap = 1000, beats = 0, nlast = 0;
   logic [W-1:0] first_data = '0, prev_data = '0;
   logic prev_stall = 1'b0, prev_last = 1'b0, prev_empty = 1'b1;

   always @(negedge clk) begin
      beat_t e;
      logic  have;
      cyc++;
      if (prev_empty && !fifo_empty && fall_cyc < 0) fall_cyc = cyc;
      if (fifo_read) begin
         rd_cnt++;
         check("pop_nonempty", fifo_empty, 1'b0);
         if (first_rd < 0) first_rd = cyc;
      end
      if (out_valid && first_valid < 0) first_valid = cyc;
      run = out_valid ? run + 1 : 0;
      if (run > max_run) max_run = run;
      if (prev_stall && out_valid) begin
         check("stall_data", out_data, prev_data);
         check("stall_last", out_last, prev_last);
      end
      if (out_valid && out_ready) begin
         have = (exp_q.size() != 0);
         check("beat_expected", have, 1'b1);
         if (have) begin
            e = exp_q.pop_front();
            check("beat_data", out_data, e.data);
            check("beat_last", out_last, e.last);
            if (beats == 0) first_data = out_data;
            if (e.idx == 0 && last_m >= 0 && (cyc - last_m) < min_gap) min_gap = cyc - last_m;
            if (e.last) begin
               last_m = cyc;
               nlast++;
            end
            beats++;
         end
      end
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
      prev_last  = out_last;
      prev_empty = fifo_empty;
   end

   int         rdy_mode = 0;
   int         pat_i = 0;
   logic [3:0] pat = 4'b1001;

   task automatic tick();
      @(posedge clk);
      #1;
      case (rdy_mode)
         0: out_ready = 1'b1;
         1: begin
            out_ready = pat[pat_i % 4];
            pat_i++;
         end
         default: out_ready = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic reset_stats();
      fall_cyc = -1; first_rd = -1; first_valid = -1; rd_cnt = 0;
      max_run = 0; last_m = -1; min_gap = 1000; beats = 0; nlast = 0;
   endtask

   task automatic push_tile(input logic [TW-1:0] t);
      push_q.push_back(t);
      pushed++;
   endtask

   function automatic logic [TW-1:0] rand_tile();
      logic [TW-1:0] t;
      for (int k = 0; k < 16; k++) t[k*W +: W] = W'($urandom);
      return t;
   endfunction

   task automatic drain(input int budget);
      for (int i = 0; i < budget; i++) begin
         tick();
         if (push_q.size() == 0 && fifo_q.size() == 0 && exp_q.size() == 0
             && !busy && !fifo_read) break;
      end
      check("drain_exp_left", exp_q.size(), 0);
      check("drain_busy", busy, 1'b0);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_fifo_read"}, fifo_read, 1'b0);
      check({tag, "_out_valid"}, out_valid, 1'b0);
      check({tag, "_out_last"}, out_last, 1'b0);
      check({tag, "_busy"}, busy, 1'b0);
      check({tag, "_out_data"}, out_data, '0);
   endtask

   initial begin
      logic [TW-1:0] t;
      logic [TW-1:0] tile_b;

      rdy_mode = 0;
      reset = 1'b0;
      repeat (3) tick();
      check_reset_outputs("por");
      reset = 1'b1;
      tick();

      // single tile, element k = 0x0100 + k
      reset_stats();
      for (int k = 0; k < 16; k++) t[k*W +: W] = 16'h0100 + 16'(k);
      push_tile(t);
      drain(100);
      check("t1_pops", rd_cnt, 1);
      check("t1_beats", beats, 16);
      check("t1_lasts", nlast, 1);
      check("t1_run", max_run, 16);
      check("t1_read_lat", first_rd - fall_cyc, 1);
      check("t1_valid_lat", first_valid - fall_cyc, 3);

      // backpressure 1,0,0,1 pattern
      rdy_mode = 1;
      pat_i = 0;
      reset_stats();
      push_tile(rand_tile());
      drain(200);
      check("bp_pops", rd_cnt, 1);
      check("bp_beats", beats, 16);
      check("bp_lasts", nlast, 1);

      // empty FIFO
      rdy_mode = 2;
      for (int i = 0; i < 50; i++) begin
         tick();
         check("empty_read", fifo_read, 1'b0);
         check("empty_valid", out_valid, 1'b0);
         check("empty_busy", busy, 1'b0);
      end

      // back-to-back tiles
      rdy_mode = 0;
      reset_stats();
      for (int i = 0; i < 3; i++) push_tile(rand_tile());
      drain(300);
      check("b2b_beats", beats, 48);
      check("b2b_lasts", nlast, 3);
`ifdef TILE_READER_PREFETCH_EN
      check("b2b_run", max_run, 48);
      check("b2b_gap", min_gap, 1);
`else
      check("b2b_run", max_run, 16);
      check("b2b_gap_ge4", (min_gap >= 4), 1'b1);
`endif

      // reset in the cycle after element 5 transfers
      rdy_mode = 0;
      reset_stats();
      push_tile(rand_tile());
      for (int i = 0; i < 100; i++) begin
         tick();
         if (beats >= 6) break;
      end
      check("rst_reached", beats, 6);
      reset = 1'b0;
      out_ready = 1'b0;
      @(posedge clk);
      #1;
      check_reset_outputs("mid");
      reset = 1'b1;
      reset_stats();
      tile_b = rand_tile();
      push_tile(tile_b);
      drain(100);
      check("rst_next_beats", beats, 16);
      check("rst_next_first", first_data, tile_b[W-1:0]);

      // random traffic, then pop hygiene once the FIFO runs dry
      rdy_mode = 2;
      reset_stats();
      for (int i = 0; i < 4; i++) begin
         push_tile(rand_tile());
         repeat ($urandom_range(0, 30)) tick();
      end
      drain(1000);
      check("rand_beats", beats, 64);
      check("rand_lasts", nlast, 4);
      for (int i = 0; i < 20; i++) begin
         tick();
         check("dry_read", fifo_read, 1'b0);
      end
      check("pops_total", pops, pushed);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tile_reader.md
# tile_reader

Drain side of the tile FIFO. Pops one `16*WIDTH`-bit tile at a time from the FIFO read port, then streams it out as 16 `WIDTH`-bit elements over a valid/ready interface, lowest element first, with a last-element marker. It sits between the tile FIFO and the compute array row feeder. An optional prefetch buffer hides FIFO read latency between tiles.

## Interface
- `WIDTH`, default 16: element width in bits.
- `ELEMS`, default 16: elements per tile. Fixed at 16 by the FIFO word format.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low. `reset==0` at a rising edge resets the block.
- `fifo_empty`, input, 1: FIFO empty flag.
- `fifo_read`, output, 1: FIFO pop request; one cycle per pop.
- `fifo_out`, input, `16*WIDTH`: FIFO read data. Valid in the cycle after the cycle in which `fifo_read` is high.
- `out_data`, output, `WIDTH`: current element.
- `out_valid`, output, 1: `out_data` is valid.
- `out_ready`, input, 1: downstream accepts.
- `out_last`, output, 1: element 15 of the current tile, qualified by `out_valid`.
- `busy`, output, 1: the block holds or is fetching a tile (state is not IDLE).

## Operation
- **States:** IDLE, REQ, LOAD, STREAM.
- **IDLE:** if `fifo_empty==0`, go to REQ.
- **REQ:** `fifo_read=1` for exactly this cycle; go to LOAD.
- **LOAD:** capture `fifo_out` into the tile register; element counter = 0; go to STREAM.
- **STREAM:**
  - `out_valid=1`.
  - `out_data` = `tile[cnt*WIDTH +: WIDTH]`.
  - `out_last` = (`cnt==15`).
  - An element transfers when `out_valid && out_ready`. On transfer `cnt` increments (4-bit).
  - On transfer with `cnt==15`, go to IDLE (or the prefetch path, see Configuration).
- **Stall:** while `out_valid && !out_ready`, `out_data`, `out_last` and `cnt` hold stable.
- **No re-reads:** `fifo_read` is never asserted outside REQ (or the prefetch slot), and never while `fifo_empty==1`.
- **Reset values:**
  - State = IDLE.
  - `fifo_read=0`, `out_valid=0`, `out_last=0`, `busy=0`.
  - `out_data=0`, `cnt=0`, tile and prefetch registers cleared.
- **Reset mid-operation:** the current tile, and any prefetched tile, is discarded. No further elements are emitted. A tile popped from the FIFO is not restored.

## Timing
- **Latency without prefetch:** `fifo_empty` falls in cycle N. `fifo_read` is high in N+1, capture happens in N+2, and the first `out_valid` is in N+3.
- **Throughput:** 1 element/cycle while `out_ready==1`.
- **Gap without prefetch:** last element accepted in cycle M means the next tile's first element appears no earlier than M+4.
- **Outputs:** `out_valid`, `out_data`, `out_last` and `fifo_read` are pure functions of registered state. No combinational path from `out_ready` to `fifo_read`.

## Configuration
- **Macro:** `TILE_READER_PREFETCH_EN`.
- **Defined:**
  - Adds a one-tile prefetch register with a valid bit.
  - In STREAM, with the prefetch register empty, no pop outstanding and `fifo_empty==0`, assert `fifo_read` for one cycle. Capture `fifo_out` into the prefetch register the next cycle.
  - When element 15 transfers and the prefetch is valid, move the prefetch into the tile register and reset `cnt` to 0. Stay in STREAM, so the next tile's element 0 appears in M+1 (zero bubble).
  - If the prefetch is not valid at that point, behave as the undefined case.
- **Undefined:** no prefetch register; behaviour exactly as in Operation.

## Structure
- **Shared package:**
  - State enum `tile_reader_state_t` (IDLE, REQ, LOAD, STREAM).
  - Constant `TILE_ELEMS = 16`.
  - Tile typedef `tile_t` = `logic [16*WIDTH-1:0]`, or `TILE_ELEMS` combined with `WIDTH` where parameterization prevents a typedef.
- **Sub-module:** one natural sub-module, `tile_prefetch_buf`: a single-entry register with a valid bit and load/take controls. It is instantiated only under `TILE_READER_PREFETCH_EN`.

## Test plan
- **Single tile:** WIDTH=16, FIFO holds one tile with element k = 16'h0100+k, `out_ready=1`. Expect:
  - `fifo_read` pulses once.
  - 16 beats 16'h0100..16'h010F in consecutive cycles.
  - `out_last` only on 16'h010F.
  - Then IDLE with `busy=0`.
- **Backpressure:** toggle `out_ready` 1,0,0,1,… during the tile. Expect each element presented until accepted, held stable while stalled, none lost or duplicated, 16 beats total.
- **Empty FIFO:** `fifo_empty=1` for 50 cycles. Expect `fifo_read=0`, `out_valid=0`, `busy=0` throughout.
- **Back-to-back tiles:** 3 queued tiles, `out_ready=1`. Expect 48 ordered elements.
  - Without macro: at least 3 idle cycles between tiles.
  - With `TILE_READER_PREFETCH_EN`: 48 consecutive valid cycles.
- **Reset mid-tile:** `reset=0` in the cycle after element 5 transfers. Expect all outputs at reset values the next cycle, and the following tile streams from its element 0.
- **Pop hygiene:** `fifo_empty` rises in the same cycle the FIFO's last tile is popped. Expect no further `fifo_read` until `fifo_empty` falls.
